// File: rtl/condition_code_unit.sv
`default_nettype none
// ============================================================================
// condition_code_unit : CCR latch, carry feedback and branch resolution
// Revision 1.0
// ============================================================================
module condition_code_unit #(
  parameter int OP_W       = 7,
  parameter int WAIT_LIMIT = 15
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            CCR_Enable,
  input  logic            NOP_FLAG,
  input  logic            ZERO_FLAG,
  input  logic            NEGATIVE_FLAG,
  input  logic            OVERFLOW_FLAG,
  input  logic            CARRY_FLAG,
  input  logic            INR_FLAG,
  input  logic            Alu_Issue,
  input  logic            Br_Req,
  input  logic [OP_W-1:0] Br_Op,
  output logic [31:0]     CCR,
  output logic            Carry_Out,
  output logic            Br_Ack,
  output logic            Br_Taken,
  output logic            Br_Err,
  output logic            Busy
);

  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(WAIT_LIMIT);

  localparam logic [OP_W-1:0] C_OP_BEQ = OP_W'(39);
  localparam logic [OP_W-1:0] C_OP_BNE = OP_W'(40);
  localparam logic [OP_W-1:0] C_OP_BLT = OP_W'(41);
  localparam logic [OP_W-1:0] C_OP_BRA = OP_W'(64);
  localparam logic [OP_W-1:0] C_OP_BSR = OP_W'(65);
  localparam logic [OP_W-1:0] C_OP_JMP = OP_W'(16);
  localparam logic [OP_W-1:0] C_OP_JSR = OP_W'(17);
  localparam logic [OP_W-1:0] C_OP_RTS = OP_W'(18);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [OP_W-1:0]  r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ack, r_taken, r_err;
  logic             r_c, r_v, r_z, r_n, r_inr, r_inr_sticky;
  logic             r_pending;

  logic             w_flag_load;
  logic             w_req_cond;
  logic [1:0]       w_req_res;
  logic [1:0]       w_wait_res;
  logic [CNT_W-1:0] w_cnt_inc;

  // Returns {err, taken} for an opcode against a set of flags.
  function automatic logic [1:0] f_resolve(input logic [OP_W-1:0] op,
                                           input logic z, input logic n, input logic v);
    case (op)
      C_OP_BEQ: return {1'b0, z};
      C_OP_BNE: return {1'b0, ~z};
      C_OP_BLT: return {1'b0, n ^ v};
      C_OP_BRA, C_OP_BSR, C_OP_JMP, C_OP_JSR, C_OP_RTS: return 2'b01;
      default:  return 2'b10;
    endcase
  endfunction

  assign w_flag_load = CCR_Enable & ~NOP_FLAG;
  assign w_req_cond  = (Br_Op == C_OP_BEQ) || (Br_Op == C_OP_BNE) || (Br_Op == C_OP_BLT);
  assign w_req_res   = f_resolve(Br_Op, r_z, r_n, r_v);
  // A waiting branch resolves on the flags being loaded this very edge.
  assign w_wait_res  = f_resolve(r_op, ZERO_FLAG, NEGATIVE_FLAG, OVERFLOW_FLAG);
  assign w_cnt_inc   = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_c          <= 1'b0;
      r_v          <= 1'b0;
      r_z          <= 1'b0;
      r_n          <= 1'b0;
      r_inr        <= 1'b0;
      r_inr_sticky <= 1'b0;
      r_pending    <= 1'b0;
    end else begin
      if (w_flag_load) begin
        r_c          <= CARRY_FLAG;
        r_v          <= OVERFLOW_FLAG;
        r_z          <= ZERO_FLAG;
        r_n          <= NEGATIVE_FLAG;
        r_inr        <= INR_FLAG;
        r_inr_sticky <= r_inr_sticky | INR_FLAG;
      end
      if (Alu_Issue)       r_pending <= 1'b1;
      else if (CCR_Enable) r_pending <= 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_taken <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack   <= 1'b0;
      r_taken <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Br_Req) begin
            r_op <= Br_Op;
            if (w_req_cond && (r_pending || Alu_Issue)) begin
              r_state <= S_WAIT;
              r_cnt   <= '0;
            end else begin
              r_state <= S_RESP;
              r_ack   <= 1'b1;
              r_err   <= w_req_res[1];
              r_taken <= w_req_res[0];
            end
          end
        end
        S_WAIT: begin
          if (w_flag_load) begin
            r_state <= S_RESP;
            r_ack   <= 1'b1;
            r_err   <= w_wait_res[1];
            r_taken <= w_wait_res[0];
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == C_CNT_MAX) begin
              r_state <= S_RESP;
              r_ack   <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign CCR       = {26'b0, r_inr_sticky, r_inr, r_n, r_z, r_v, r_c};
  assign Carry_Out = r_c;
  assign Br_Ack    = r_ack;
  assign Br_Taken  = r_taken;
  assign Br_Err    = r_err;
  assign Busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_condition_code_unit.sv
`default_nettype none
// ============================================================================
// tb_condition_code_unit : directed vector table, corner sequences, random run
// Revision 1.0
// ============================================================================
module tb_condition_code_unit;

  localparam int WAIT_LIMIT = 15;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        en = 1'b0, nop = 1'b0, zf = 1'b0, nf = 1'b0, vf = 1'b0, cf = 1'b0, inr = 1'b0;
  logic        issue = 1'b0, req = 1'b0;
  logic [6:0]  op = '0;
  logic [31:0] CCR;
  logic        Carry_Out, Br_Ack, Br_Taken, Br_Err, Busy;

  int n_checks = 0;
  int n_errors = 0;

  condition_code_unit #(.OP_W(7), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .CCR_Enable(en), .NOP_FLAG(nop),
    .ZERO_FLAG(zf), .NEGATIVE_FLAG(nf), .OVERFLOW_FLAG(vf), .CARRY_FLAG(cf),
    .INR_FLAG(inr), .Alu_Issue(issue), .Br_Req(req), .Br_Op(op),
    .CCR(CCR), .Carry_Out(Carry_Out), .Br_Ack(Br_Ack), .Br_Taken(Br_Taken),
    .Br_Err(Br_Err), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  // Reference model: architectural flags plus an in-flight request record.
  bit mc, mv, mz, mn, minr, msticky, mpend;
  bit m_waiting, m_responding;
  int m_waited, m_op;
  bit e_ack, e_taken, e_err;

  function automatic void model_reset();
    {mc, mv, mz, mn, minr, msticky, mpend} = '0;
    m_waiting = 0; m_responding = 0; m_waited = 0; m_op = 0;
    e_ack = 0; e_taken = 0; e_err = 0;
  endfunction

  function automatic void resolve(input int o, input bit z, input bit n, input bit v,
                                  output bit taken, output bit err);
    taken = 0; err = 0;
    case (o)
      39: taken = z;
      40: taken = !z;
      41: taken = n ^ v;
      64, 65, 16, 17, 18: taken = 1;
      default: err = 1;
    endcase
  endfunction

  function automatic void model_edge();
    bit load = en && !nop;
    bit t, e;
    e_ack = 0; e_taken = 0; e_err = 0;
    if (m_responding) begin
      m_responding = 0;
    end else if (m_waiting) begin
      if (load) begin
        resolve(m_op, zf, nf, vf, t, e);
        e_ack = 1; e_taken = t; e_err = e;
      end else begin
        m_waited++;
        if (m_waited >= WAIT_LIMIT) begin
          e_ack = 1; e_err = 1;
        end
      end
      if (e_ack) begin m_waiting = 0; m_responding = 1; end
    end else if (req) begin
      if ((int'(op) inside {39, 40, 41}) && (mpend || issue)) begin
        m_waiting = 1; m_waited = 0; m_op = int'(op);
      end else begin
        resolve(int'(op), mz, mn, mv, t, e);
        e_ack = 1; e_taken = t; e_err = e; m_responding = 1;
      end
    end
    if (load) begin
      mc = cf; mv = vf; mz = zf; mn = nf; minr = inr; msticky = msticky | inr;
    end
    if (issue) mpend = 1;
    else if (en) mpend = 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [37:0] dut_obs();
    return {CCR, Carry_Out, Br_Ack, Br_Taken, Br_Err, Busy};
  endfunction

  function automatic logic [37:0] model_obs();
    return {26'b0, msticky, minr, mn, mz, mv, mc, mc, e_ack, e_taken, e_err,
            m_waiting || m_responding};
  endfunction

  task automatic step();
    @(posedge Clock);
    model_edge();
    #1;
    chk("model", 64'(dut_obs()), 64'(model_obs()));
  endtask

  task automatic drive(input logic i_en, input logic i_nop, input logic i_z, input logic i_n,
                       input logic i_v, input logic i_c, input logic i_inr, input logic i_issue,
                       input logic i_req, input logic [6:0] i_op);
    en = i_en; nop = i_nop; zf = i_z; nf = i_n; vf = i_v; cf = i_c; inr = i_inr;
    issue = i_issue; req = i_req; op = i_op;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'd0);
  endtask

  typedef struct {
    logic en, nop, z, n, v, c, inr, issue, req;
    logic [6:0] op;
    logic [5:0] ccr;
    logic ack, taken, err, busy;
  } vec_t;

  vec_t tbl[32];

  function automatic vec_t mk(input logic a_en, input logic a_nop, input logic a_z,
                              input logic a_n, input logic a_v, input logic a_c,
                              input logic a_inr, input logic a_issue, input logic a_req,
                              input int a_op, input logic [5:0] a_ccr, input logic a_ack,
                              input logic a_taken, input logic a_err, input logic a_busy);
    vec_t r;
    r.en = a_en; r.nop = a_nop; r.z = a_z; r.n = a_n; r.v = a_v; r.c = a_c; r.inr = a_inr;
    r.issue = a_issue; r.req = a_req; r.op = 7'(a_op); r.ccr = a_ccr;
    r.ack = a_ack; r.taken = a_taken; r.err = a_err; r.busy = a_busy;
    return r;
  endfunction

  initial begin
    int ops[9] = '{39, 40, 41, 64, 65, 16, 17, 18, 7};
    //          en nop z n v c inr iss req op   ccr    ack tk er busy
    tbl[0]  = mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 0,  6'h05, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 39, 6'h05, 1, 1, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 40, 6'h05, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 40, 6'h05, 1, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  6'h05, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  6'h05, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 41, 6'h05, 0, 0, 0, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  6'h05, 0, 0, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  6'h05, 0, 0, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  6'h05, 0, 0, 0, 1);
    tbl[10] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  6'h08, 1, 1, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  6'h08, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  6'h08, 1, 0, 1, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  6'h08, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  6'h08, 0, 0, 0, 0);
    tbl[15] = mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0,  6'h08, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 39, 6'h08, 1, 0, 0, 1);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  6'h08, 0, 0, 0, 0);
    tbl[18] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  6'h30, 0, 0, 0, 0);
    tbl[19] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  6'h24, 0, 0, 0, 0);
    tbl[20] = mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0,  6'h21, 0, 0, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 39, 6'h21, 0, 0, 0, 1);
    tbl[22] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  6'h24, 1, 1, 0, 1);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  6'h24, 0, 0, 0, 0);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  6'h24, 0, 0, 0, 0);
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 64, 6'h24, 1, 1, 0, 1);
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  6'h24, 0, 0, 0, 0);
    tbl[27] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  6'h20, 0, 0, 0, 0);
    tbl[28] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 40, 6'h20, 0, 0, 0, 1);
    tbl[29] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  6'h20, 0, 0, 0, 1);
    tbl[30] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  6'h20, 1, 1, 0, 1);
    tbl[31] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  6'h20, 0, 0, 0, 0);

    model_reset();
    idle();
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_state", 64'(dut_obs()), 64'(0));
    @(negedge Clock);
    Reset_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].nop, tbl[i].z, tbl[i].n, tbl[i].v, tbl[i].c, tbl[i].inr,
            tbl[i].issue, tbl[i].req, tbl[i].op);
      step();
      chk($sformatf("vec%0d", i), 64'(dut_obs()),
          64'({26'b0, tbl[i].ccr, tbl[i].ccr[0], tbl[i].ack, tbl[i].taken, tbl[i].err,
               tbl[i].busy}));
    end

    // Timeout: conditional branch stalled with no flags ever arriving.
    idle(); issue = 1; step();
    idle(); req = 1; op = 7'd39; step();
    idle();
    for (int k = 1; k < WAIT_LIMIT; k++) begin
      step();
      chk("timeout_wait", 64'({Br_Ack, Busy}), 64'(2'b01));
    end
    step();
    chk("timeout_ack", 64'({Br_Ack, Br_Taken, Br_Err}), 64'(3'b101));
    step();
    chk("timeout_idle", 64'({Br_Ack, Busy}), 64'(2'b00));

    // Asynchronous reset while stalled in WAIT.
    drive(1, 0, 1, 0, 0, 1, 0, 1, 0, 7'd0); step();
    idle(); req = 1; op = 7'd40; step();
    idle(); step(); step();
    chk("pre_reset_busy", 64'(Busy), 64'(1));
    #3;
    Reset_n = 1'b0;
    #1;
    chk("async_reset", 64'(dut_obs()), 64'(0));
    model_reset();
    @(posedge Clock);
    #1;
    chk("reset_hold", 64'(dut_obs()), 64'(0));
    #2;
    Reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_reset_noack", 64'({Br_Ack, Busy}), 64'(2'b00));
    end

    // Randomised run against the reference model.
    for (int k = 0; k < 600; k++) begin
      int idx = $urandom_range(0, 9);
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
            (idx == 9) ? 7'($urandom_range(0, 127)) : 7'(ops[idx]));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
